vdma_wr_arbiter: RTL and testbench

- Round-robin scheduler that shares one AXI write engine (one write-state core plus its AW/W/B port) between NUM independent write channels.
- Each channel is a frame writer issuing burst or tail requests: level req plus len/addr, handshaked by resp and done.
- The arbiter grants one channel per burst and forwards that channel's request to the core.
- It steers the core's pull_data_en back to the granted channel's FIFO and muxes that channel's FIFO data onto the shared AXI wdata.

---
 rtl/vdma_wr_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_vdma_wr_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdma_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write core (AW/W/B) between NUM frame-writer channels.
// Latency: request seen in IDLE at edge k -> core_write_req from edge k+1; at least one IDLE cycle between bursts.
// Backpressure: ch_req is a level held until ch_resp; W data pulled only on core_pull_data_en & axi_wready.
//
// Ports:
//   clock, rst                 single clock, synchronous active-high reset
//   ch_req/ch_len/ch_addr      per-channel burst request, packed len/addr (channel i at [i*W +: W])
//   ch_resp/ch_done            one-cycle accept / complete pulses, only ever to the granted channel
//   ch_pull/ch_wdata           per-channel FIFO read strobe and packed FIFO outputs
//   core_write_req/len/addr    request to the shared write core, len/addr latched at grant
//   core_req_resp/done         core accept and burst-complete pulses
//   core_pull_data_en          core W-phase data enable
//   axi_wready/axi_wdata       AXI W ready and muxed write data
//   grant_id, busy             current/last granted channel, high while not IDLE
module vdma_wr_arbiter #(
  parameter int NUM   = 4,
  parameter int IDW   = 2,
  parameter int ASIZE = 29,
  parameter int LSIZE = 9,
  parameter int DSIZE = 256
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [NUM-1:0]         ch_req,
  input  logic [NUM*LSIZE-1:0]   ch_len,
  input  logic [NUM*ASIZE-1:0]   ch_addr,
  output logic [NUM-1:0]         ch_resp,
  output logic [NUM-1:0]         ch_done,
  output logic [NUM-1:0]         ch_pull,
  input  logic [NUM*DSIZE-1:0]   ch_wdata,
  output logic                   core_write_req,
  output logic [LSIZE-1:0]       core_req_len,
  output logic [ASIZE-1:0]       core_req_addr,
  input  logic                   core_req_resp,
  input  logic                   core_req_done,
  input  logic                   core_pull_data_en,
  input  logic                   axi_wready,
  output logic [DSIZE-1:0]       axi_wdata,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Most recently granted channel; the scan for the next winner starts one past it.
  logic [IDW-1:0]   last_id;
  logic             grant_take;

  logic             win_vld;
  logic [IDW-1:0]   win_id;
  logic [LSIZE-1:0] win_len;
  logic [ASIZE-1:0] win_addr;

  logic [2*NUM-1:0] req_dbl;
  logic [NUM-1:0]   req_rot;

  // ---------------------------------------------------------------------------
  // Round-robin winner.
  // Doubling the request vector and shifting it right by last_id+1 puts the
  // channel after last_id at bit 0, so the first set bit of req_rot is the
  // winner and the wrap-around is handled without any modulo on the index.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_dbl = {ch_req, ch_req} >> (int'(last_id) + 1);
    req_rot = req_dbl[NUM-1:0];
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 0; k < NUM; k++) begin
      if (!win_vld && req_rot[k]) begin
        win_vld = 1'b1;
        win_id  = IDW'((int'(last_id) + 1 + k) % NUM);
      end
    end
  end

  // Length/address of the winning channel, captured at grant.
  always_comb begin
    win_len  = '0;
    win_addr = '0;
    for (int i = 0; i < NUM; i++) begin
      if (win_id == IDW'(i)) begin
        win_len  = ch_len[i*LSIZE +: LSIZE];
        win_addr = ch_addr[i*ASIZE +: ASIZE];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A resp arriving outside REQ or a done outside BUSY falls through the
  // case unchanged; a done coinciding with resp in REQ is likewise ignored.
  always_comb begin
    state_nxt      = state;
    core_write_req = 1'b0;
    busy           = 1'b0;
    grant_take     = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          grant_take = 1'b1;
          state_nxt  = REQ;
        end
      end
      REQ: begin
        core_write_req = 1'b1;
        busy           = 1'b1;
        if (core_req_resp) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (core_req_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Grant registers: only move on IDLE->REQ, so later changes on the channel
  // len/addr inputs cannot disturb a request already handed to the core.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (rst) begin
      grant_id      <= '0;
      last_id       <= IDW'(NUM - 1);
      core_req_len  <= '0;
      core_req_addr <= '0;
    end else if (grant_take) begin
      grant_id      <= win_id;
      last_id       <= win_id;
      core_req_len  <= win_len;
      core_req_addr <= win_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel pulses and FIFO steering.
  // Pulses are suppressed while rst is high so an interrupted burst never
  // reports resp/done on its way out.
  // ---------------------------------------------------------------------------
  always_comb begin
    ch_resp = '0;
    ch_done = '0;
    ch_pull = '0;
    for (int i = 0; i < NUM; i++) begin
      if (grant_id == IDW'(i) && !rst) begin
        ch_resp[i] = (state == REQ)  && core_req_resp;
        ch_done[i] = (state == BUSY) && core_req_done;
        ch_pull[i] = ((state == BUSY) || (state == REQ)) && core_pull_data_en && axi_wready;
      end
    end
  end

  // Write data follows grant_id in every state; the FIFO head of the granted
  // channel is already on the bus by the time the core starts pulling.
  always_comb begin
    axi_wdata = '0;
    for (int i = 0; i < NUM; i++) begin
      if (grant_id == IDW'(i)) begin
        axi_wdata = ch_wdata[i*DSIZE +: DSIZE];
      end
    end
  end

endmodule

// File: tb/tb_vdma_wr_arbiter.sv
module tb_vdma_wr_arbiter;

  localparam int NUM   = 4;
  localparam int IDW   = 2;
  localparam int ASIZE = 29;
  localparam int LSIZE = 9;
  localparam int DSIZE = 256;

  logic                 clock = 1'b0;
  logic                 rst;
  logic [NUM-1:0]       ch_req;
  logic [NUM*LSIZE-1:0] ch_len;
  logic [NUM*ASIZE-1:0] ch_addr;
  logic [NUM-1:0]       ch_resp;
  logic [NUM-1:0]       ch_done;
  logic [NUM-1:0]       ch_pull;
  logic [NUM*DSIZE-1:0] ch_wdata;
  logic                 core_write_req;
  logic [LSIZE-1:0]     core_req_len;
  logic [ASIZE-1:0]     core_req_addr;
  logic                 core_req_resp;
  logic                 core_req_done;
  logic                 core_pull_data_en;
  logic                 axi_wready;
  logic [DSIZE-1:0]     axi_wdata;
  logic [IDW-1:0]       grant_id;
  logic                 busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          id;
    logic [LSIZE-1:0] len;
    logic [ASIZE-1:0] addr;
  } exp_t;

  exp_t exp_q[$];

  always #5 clock = ~clock;

  vdma_wr_arbiter #(
    .NUM(NUM), .IDW(IDW), .ASIZE(ASIZE), .LSIZE(LSIZE), .DSIZE(DSIZE)
  ) dut (
    .clock             (clock),
    .rst               (rst),
    .ch_req            (ch_req),
    .ch_len            (ch_len),
    .ch_addr           (ch_addr),
    .ch_resp           (ch_resp),
    .ch_done           (ch_done),
    .ch_pull           (ch_pull),
    .ch_wdata          (ch_wdata),
    .core_write_req    (core_write_req),
    .core_req_len      (core_req_len),
    .core_req_addr     (core_req_addr),
    .core_req_resp     (core_req_resp),
    .core_req_done     (core_req_done),
    .core_pull_data_en (core_pull_data_en),
    .axi_wready        (axi_wready),
    .axi_wdata         (axi_wdata),
    .grant_id          (grant_id),
    .busy              (busy)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the active edge, outputs are sampled 1 later.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic push_exp(input int id);
    exp_t e;
    e.id   = id;
    e.len  = ch_len[id*LSIZE +: LSIZE];
    e.addr = ch_addr[id*ASIZE +: ASIZE];
    exp_q.push_back(e);
  endtask

  task automatic randomize_wdata();
    for (int j = 0; j < NUM*DSIZE/32; j++) ch_wdata[j*32 +: 32] = $urandom;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!core_write_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_timeout", core_write_req, 1'b1);
  endtask

  // Acts as the write core for one burst and checks it against the next
  // scoreboard entry. clr_* masks drop ch_req bits at resp/done time.
  task automatic serve(input logic [NUM-1:0] clr_resp, input logic [NUM-1:0] clr_done,
                       input bit data, input bit late);
    exp_t e;
    logic [NUM-1:0] oh;
    logic [2:0] wr_pat;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 1'b1, 1'b0);
      return;
    end
    e  = exp_q.pop_front();
    oh = NUM'(1) << e.id;
    wait_req();
    #1;
    chk("grant_id", grant_id, e.id);
    chk("req_len", core_req_len, e.len);
    chk("req_addr", core_req_addr, e.addr);
    chk("busy_req", busy, 1'b1);
    core_req_resp = 1'b1;
    #1;
    chk("ch_resp", ch_resp, oh);
    chk("ch_done_in_req", ch_done, '0);
    ch_req = ch_req & ~clr_resp;
    if (late) begin
      ch_len[e.id*LSIZE +: LSIZE]  = 9'd3;
      ch_addr[e.id*ASIZE +: ASIZE] = 29'h55;
    end
    tick();
    core_req_resp = 1'b0;
    #1;
    chk("ch_resp_clr", ch_resp, '0);
    chk("req_off_busy", core_write_req, 1'b0);
    chk("busy_busy", busy, 1'b1);
    if (data) begin
      wr_pat = 3'b101;
      for (int c = 0; c < 3; c++) begin
        core_pull_data_en = 1'b1;
        axi_wready        = wr_pat[2-c];
        randomize_wdata();
        #1;
        chk("ch_pull", ch_pull, wr_pat[2-c] ? oh : '0);
        chk("axi_wdata", axi_wdata, ch_wdata[e.id*DSIZE +: DSIZE]);
        tick();
      end
      core_pull_data_en = 1'b0;
      axi_wready        = 1'b0;
    end
    tick();
    #1;
    chk("len_hold", core_req_len, e.len);
    chk("addr_hold", core_req_addr, e.addr);
    core_req_done = 1'b1;
    ch_req = ch_req & ~clr_done;
    #1;
    chk("ch_done", ch_done, oh);
    tick();
    core_req_done = 1'b0;
    #1;
    chk("ch_done_clr", ch_done, '0);
    chk("busy_idle", busy, 1'b0);
    chk("idle_gap", core_write_req, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    ch_req = '0;
    core_req_resp = 1'b0;
    core_req_done = 1'b0;
    core_pull_data_en = 1'b0;
    axi_wready = 1'b0;
    ch_wdata = '0;
    for (int i = 0; i < NUM; i++) begin
      ch_len[i*LSIZE +: LSIZE]  = LSIZE'(16 + i);
      ch_addr[i*ASIZE +: ASIZE] = ASIZE'(32'h100 * (i + 1));
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req", core_write_req, 1'b0);
    chk("rst_len", core_req_len, 0);
    chk("rst_addr", core_req_addr, 0);

    // Stray core pulses in IDLE must be ignored.
    core_req_resp = 1'b1;
    core_req_done = 1'b1;
    #1;
    chk("idle_resp_ign", ch_resp, '0);
    chk("idle_done_ign", ch_done, '0);
    tick();
    core_req_resp = 1'b0;
    core_req_done = 1'b0;
    #1;
    chk("idle_stay", busy, 1'b0);

    // Fairness: all channels held for 8 bursts.
    ch_req = 4'b1111;
    for (int b = 0; b < 8; b++) push_exp(b % NUM);
    for (int b = 0; b < 8; b++) serve('0, (b == 7) ? 4'b1111 : 4'b0000, 1'b0, 1'b0);

    // Skip idle channels: get last=1, then 1 and 3 requesting -> 3 then 1.
    ch_req = 4'b0010;
    push_exp(1);
    serve('0, 4'b0010, 1'b0, 1'b0);
    ch_req = 4'b1010;
    push_exp(3);
    push_exp(1);
    serve('0, 4'b1000, 1'b0, 1'b0);
    serve('0, 4'b0010, 1'b0, 1'b0);

    // Single requester with exact one-cycle latency.
    ch_len[2*LSIZE +: LSIZE]  = 9'd15;
    ch_addr[2*ASIZE +: ASIZE] = 29'h1000;
    ch_req = 4'b0100;
    push_exp(2);
    tick();
    #1;
    chk("latency", core_write_req, 1'b1);
    serve(4'b0100, '0, 1'b0, 1'b0);

    // Data steering on grant 1.
    ch_req = 4'b0010;
    push_exp(1);
    serve(4'b0010, '0, 1'b1, 1'b0);

    // Late len/addr change after grant on channel 0.
    ch_len[0 +: LSIZE] = 9'd15;
    ch_req = 4'b0001;
    push_exp(0);
    serve(4'b0001, '0, 1'b0, 1'b1);

    // Reset in the middle of a burst on channel 2.
    ch_req = 4'b0100;
    push_exp(2);
    e = exp_q.pop_front();
    wait_req();
    #1;
    chk("rb_grant", grant_id, e.id);
    core_req_resp = 1'b1;
    tick();
    core_req_resp = 1'b0;
    ch_req = '0;
    #1;
    chk("rb_busy", busy, 1'b1);
    core_pull_data_en = 1'b1;
    axi_wready = 1'b1;
    ch_req = 4'b1111;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    core_req_done = 1'b1;
    push_exp(0);
    #1;
    chk("rb_busy0", busy, 1'b0);
    chk("rb_grant0", grant_id, 0);
    chk("rb_req0", core_write_req, 1'b0);
    chk("rb_len0", core_req_len, 0);
    chk("rb_addr0", core_req_addr, 0);
    chk("rb_pull0", ch_pull, '0);
    chk("rb_done0", ch_done, '0);
    chk("rb_resp0", ch_resp, '0);
    tick();
    core_req_done = 1'b0;
    core_pull_data_en = 1'b0;
    axi_wready = 1'b0;
    serve('0, 4'b1111, 1'b0, 1'b0);

    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
